// File: rtl/fp_int_to_fp.sv
// Integer-to-floating-point converter for FCVT.S.W/WU and FCVT.D.W/WU.
// It normalises one bit per cycle and then rounds in a single cycle.
`timescale 1ns/1ps
module fp_int_to_fp #(
    parameter int FLEN = 32
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            start,
    input  logic [31:0]     int_operand,
    input  logic            is_unsigned,
    input  logic [2:0]      rounding_mode,
    output logic            busy,
    output logic            done,
    output logic [FLEN-1:0] result,
    output logic            flag_nx,
    output logic [1:0]      dbg_state
);
    // Handshake: start is accepted only on a rising edge where busy=0. busy stays
    // high from the cycle after acceptance through the done cycle. done pulses for
    // one cycle, and result/flag_nx are valid then and hold until the next accepted start.
    typedef enum logic [1:0] {IDLE, NORM, ROUND, DONE} state_t;

    state_t      state;
    logic        sign_q;
    logic [31:0] mag_q;
    logic [5:0]  exp_q;
    logic [2:0]  rm_q;

    logic            in_sign;
    logic [31:0]     in_mag;
    logic [FLEN-1:0] round_res;
    logic            round_nx;

    assign dbg_state = state;
    assign in_sign   = !is_unsigned && int_operand[31];
    assign in_mag    = in_sign ? (~int_operand + 32'd1) : int_operand;

    generate
        if (FLEN == 32) begin : g_single
            logic [22:0] man;
            logic        g_bit;
            logic        s_bit;
            logic        up;
            logic [23:0] man_sum;
            logic [5:0]  exp_r;

            always_comb begin
                man   = mag_q[30:8];
                g_bit = mag_q[7];
                s_bit = |mag_q[6:0];
                case (rm_q)
                    3'b001:  up = 1'b0;
                    3'b010:  up = sign_q && (g_bit || s_bit);
                    3'b011:  up = !sign_q && (g_bit || s_bit);
                    3'b100:  up = g_bit;
                    default: up = g_bit && (s_bit || man[0]);
                endcase
                // A carry out of the mantissa leaves the low 23 bits at zero and bumps the exponent.
                man_sum   = {1'b0, man} + {23'd0, up};
                exp_r     = exp_q + {5'd0, man_sum[23]};
                round_res = {sign_q, {2'b00, exp_r} + 8'd127, man_sum[22:0]};
                round_nx  = g_bit || s_bit;
            end
        end else begin : g_double
            logic unused_dbl;
            assign unused_dbl = ^rm_q;
            // Every 32-bit integer fits in a double mantissa, so the conversion is always exact.
            assign round_res = {sign_q, {5'd0, exp_q} + 11'd1023, mag_q[30:0], 21'd0};
            assign round_nx  = 1'b0;
        end
    endgenerate

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            result  <= '0;
            flag_nx <= 1'b0;
            sign_q  <= 1'b0;
            mag_q   <= '0;
            exp_q   <= '0;
            rm_q    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        sign_q <= in_sign;
                        mag_q  <= in_mag;
                        rm_q   <= rounding_mode;
                        exp_q  <= 6'd31;
                        busy   <= 1'b1;
                        if (in_mag == 32'd0) begin
                            result  <= '0;
                            flag_nx <= 1'b0;
                            done    <= 1'b1;
                            state   <= DONE;
                        end else begin
                            state <= NORM;
                        end
                    end
                end
                NORM: begin
                    if (mag_q[31]) begin
                        state <= ROUND;
                    end else begin
                        mag_q <= {mag_q[30:0], 1'b0};
                        exp_q <= exp_q - 6'd1;
                    end
                end
                ROUND: begin
                    result  <= round_res;
                    flag_nx <= round_nx;
                    done    <= 1'b1;
                    state   <= DONE;
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fp_int_to_fp.sv
// Directed bench for fp_int_to_fp: single- and double-precision instances share clock and reset.
`timescale 1ns/1ps
module tb_fp_int_to_fp;
    logic        clk;
    logic        reset_n;

    logic        st32, uns32, busy32, done32, nx32;
    logic [31:0] op32, res32;
    logic [2:0]  rm32;
    logic [1:0]  dbg32;

    logic        st64, uns64, busy64, done64, nx64;
    logic [31:0] op64;
    logic [63:0] res64;
    logic [2:0]  rm64;
    logic [1:0]  dbg64;

    int compared   = 0;
    int mismatched = 0;

    fp_int_to_fp #(.FLEN(32)) dut32 (
        .clk(clk), .reset_n(reset_n), .start(st32), .int_operand(op32),
        .is_unsigned(uns32), .rounding_mode(rm32), .busy(busy32), .done(done32),
        .result(res32), .flag_nx(nx32), .dbg_state(dbg32)
    );

    fp_int_to_fp #(.FLEN(64)) dut64 (
        .clk(clk), .reset_n(reset_n), .start(st64), .int_operand(op64),
        .is_unsigned(uns64), .rounding_mode(rm64), .busy(busy64), .done(done64),
        .result(res64), .flag_nx(nx64), .dbg_state(dbg64)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issues one conversion and returns the cycle (numbered from the accepting edge)
    // in which done was seen; returns in the following IDLE cycle so the next call is back-to-back.
    task automatic run_op(input string tag, input bit w64, input logic [31:0] op,
                          input logic uns, input logic [2:0] rm,
                          output logic [63:0] res, output logic nx, output int cyc);
        logic busy_ok;
        busy_ok = 1'b1;
        @(negedge clk);
        if (w64) begin st64 = 1'b1; op64 = op; uns64 = uns; rm64 = rm; end
        else     begin st32 = 1'b1; op32 = op; uns32 = uns; rm32 = rm; end
        @(posedge clk); #1;
        st32 = 1'b0;
        st64 = 1'b0;
        cyc = 1;
        while (!(w64 ? done64 : done32) && cyc < 60) begin
            if (!(w64 ? busy64 : busy32)) busy_ok = 1'b0;
            @(posedge clk); #1;
            cyc++;
        end
        if (!(w64 ? busy64 : busy32)) busy_ok = 1'b0;
        res = w64 ? res64 : {32'd0, res32};
        nx  = w64 ? nx64 : nx32;
        check({tag, "_busy_held"}, {63'd0, busy_ok}, 64'd1);
        @(posedge clk); #1;
        check({tag, "_idle_after"}, {62'd0, (w64 ? busy64 : busy32), (w64 ? done64 : done32)}, 64'd0);
    endtask

    logic [63:0] r;
    logic        n;
    int          c;

    initial begin
        reset_n = 1'b0;
        st32 = 0; op32 = 0; uns32 = 0; rm32 = 0;
        st64 = 0; op64 = 0; uns64 = 0; rm64 = 0;
        #12;
        check("reset_outputs32", {29'd0, busy32, done32, nx32, res32}, 64'd0);
        check("reset_outputs64", {busy64, done64, nx64}, 64'd0);
        check("reset_result64", res64, 64'd0);
        @(negedge clk);
        reset_n = 1'b1;

        run_op("one_s", 0, 32'h0000_0001, 1'b0, 3'b000, r, n, c);
        check("one_s_res", r, 64'h3F80_0000);
        check("one_s_nx", {63'd0, n}, 64'd0);
        check("one_s_cycle", c, 34);
        check("one_s_hold", {32'd0, res32}, 64'h3F80_0000);

        run_op("m1_s", 0, 32'hFFFF_FFFF, 1'b0, 3'b000, r, n, c);
        check("m1_s_res", r, 64'hBF80_0000);
        check("m1_s_nx", {63'd0, n}, 64'd0);

        run_op("m1_u_rne", 0, 32'hFFFF_FFFF, 1'b1, 3'b000, r, n, c);
        check("m1_u_rne_res", r, 64'h4F80_0000);
        check("m1_u_rne_nx", {63'd0, n}, 64'd1);
        check("m1_u_rne_cycle", c, 3);

        run_op("m1_u_rtz", 0, 32'hFFFF_FFFF, 1'b1, 3'b001, r, n, c);
        check("m1_u_rtz_res", r, 64'h4F7F_FFFF);
        check("m1_u_rtz_nx", {63'd0, n}, 64'd1);

        run_op("min_s", 0, 32'h8000_0000, 1'b0, 3'b000, r, n, c);
        check("min_s_res", r, 64'hCF00_0000);
        check("min_s_nx", {63'd0, n}, 64'd0);
        check("min_s_cycle", c, 3);

        run_op("tie_rne", 0, 32'h0100_0001, 1'b0, 3'b000, r, n, c);
        check("tie_rne_res", r, 64'h4B80_0000);
        check("tie_rne_nx", {63'd0, n}, 64'd1);
        check("tie_rne_cycle", c, 10);

        run_op("tie_rup", 0, 32'h0100_0001, 1'b0, 3'b011, r, n, c);
        check("tie_rup_res", r, 64'h4B80_0001);

        run_op("tie_rmm", 0, 32'h0100_0001, 1'b0, 3'b100, r, n, c);
        check("tie_rmm_res", r, 64'h4B80_0001);

        run_op("tie_rdn", 0, 32'h0100_0001, 1'b0, 3'b010, r, n, c);
        check("tie_rdn_res", r, 64'h4B80_0000);

        run_op("tie_rm7", 0, 32'h0100_0001, 1'b0, 3'b111, r, n, c);
        check("tie_rm7_res", r, 64'h4B80_0000);

        run_op("neg_rdn", 0, 32'hFEFF_FFFF, 1'b0, 3'b010, r, n, c);
        check("neg_rdn_res", r, 64'hCB80_0001);
        check("neg_rdn_nx", {63'd0, n}, 64'd1);

        run_op("zero", 0, 32'h0000_0000, 1'b0, 3'b000, r, n, c);
        check("zero_res", r, 64'h0);
        check("zero_nx", {63'd0, n}, 64'd0);
        check("zero_cycle", c, 1);

        run_op("dbl_m3", 1, 32'hFFFF_FFFD, 1'b0, 3'b000, r, n, c);
        check("dbl_m3_res", r, 64'hC008_0000_0000_0000);
        check("dbl_m3_nx", {63'd0, n}, 64'd0);
        check("dbl_m3_cycle", c, 33);

        // A second start in the middle of an operation must not disturb it.
        fork
            run_op("busy_ign", 0, 32'h0000_0001, 1'b0, 3'b000, r, n, c);
            begin
                repeat (5) @(negedge clk);
                st32 = 1'b1; op32 = 32'hFFFF_FFFF; uns32 = 1'b1; rm32 = 3'b001;
                @(negedge clk);
                st32 = 1'b0;
            end
        join
        check("busy_ign_res", r, 64'h3F80_0000);
        check("busy_ign_cycle", c, 34);

        // Asynchronous reset mid-NORM clears everything immediately.
        @(negedge clk);
        st32 = 1'b1; op32 = 32'h0000_0001; uns32 = 1'b0; rm32 = 3'b000;
        @(posedge clk); #1;
        st32 = 1'b0;
        repeat ($urandom_range(2, 20)) @(posedge clk);
        #3;
        check("pre_rst_busy", {63'd0, busy32}, 64'd1);
        reset_n = 1'b0;
        #1;
        check("rst_mid_outputs", {30'd0, busy32, done32, res32}, 64'd0);
        check("rst_mid_nx", {63'd0, nx32}, 64'd0);
        @(negedge clk);
        reset_n = 1'b1;

        run_op("after_rst", 0, 32'h8000_0000, 1'b0, 3'b000, r, n, c);
        check("after_rst_res", r, 64'hCF00_0000);
        check("after_rst_cycle", c, 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
